instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//  Instruction fetch sequencer: the producer end of the control decoder. Owns the program counter.
//  Drives the synchronous instruction memory and presents each 9-bit instruction with a Valid qualifier.
//  Opcode Instr[8:6] and func Instr[1:0] are split out. The decoder reads these, and its Branch/Jump
//  resolution returns here as redirect requests. Start/Done bracket one program run.
// PARAMETERS
//  PCW       8        program counter / instruction memory address width
//  IW        9        instruction width
//  OFFW      5        signed branch offset width
//  HALT_WORD 9'h1FF   instruction encoding that ends a run
// PORTS
//  Clk       in   1    clock; all state updates on rising edge
//  Reset     in   1    synchronous, active-high reset
//  Start     in   1    level; rising edge (registered) begins a run at PC 0
//  ImemAddr  out  PCW  instruction memory read address (= PC register)
//  ImemData  in   IW   instruction memory data; valid 1 cycle after ImemAddr
//  Branch    in   1    decoder: current Instr is a branch
//  Zero      in   1    ALU equal flag for current Instr
//  Jump      in   1    decoder: current Instr is a jump
//  Target    in   PCW  absolute jump target (lookup-table output)
//  Offset    in   OFFW signed branch offset, relative to InstrPC
//  Instr     out  IW   current instruction
//  Opcode    out  3    Instr[8:6]
//  Func      out  2    Instr[1:0]
//  InstrPC   out  PCW  address Instr was fetched from
//  Valid     out  1    Instr is live; decoder outputs are acted on only when 1
//  Done      out  1    run complete; held until next Start rising edge
// BEHAVIOUR
//  Reset: state IDLE; PC=0; Instr=0; InstrPC=0; Valid=0; Done=0; Start edge register=0.
//   Takes priority over every other event, including mid-run and mid-redirect.
//  States:
//   IDLE: PC held at 0; Valid=0; on Start rise -> RUN.
//   RUN:  fetch every cycle.
//   HALT: Valid=0, Done=1; on Start rise -> RUN with PC=0, Done=0.
//  Start rise = Start & ~Start_q. Start is ignored while in RUN.
//  Fetch pipeline, 1-cycle latency:
//   Edge after PC is driven: Instr<=ImemData, InstrPC<=PC, Valid<=1.
//   First Valid appears 2 cycles after the Start rise (IDLE->RUN edge, then first capture).
//  Next PC, in RUN with Valid=1, decided by current Instr; first match wins:
//   1. Instr==HALT_WORD: -> HALT next edge. Branch/Jump ignored. Valid<=0.
//   2. Jump: PC<=Target.
//   3. Branch&Zero: PC<=InstrPC+sext(Offset), mod 2^PCW.
//   4. Otherwise: PC<=PC+1.
//   Jump wins if Jump and Branch are both high.
//  Redirect (case 2 or 3):
//   The word fetched in the same cycle (old PC) is squashed: Valid<=0 next edge.
//   Result: exactly one bubble per taken redirect.
//   The cycle with Valid=0 never redirects; PC<=PC+1 in that cycle.
//  Not-taken branch (Branch&~Zero): no bubble.
//  Wrap-around: PC and branch arithmetic are modulo 2^PCW; PC at max+1 -> 0; no error flag.
//  Opcode/Func are pure slices of the registered Instr: no extra latency.
// TESTING
//  1 Reset, then Start rise; ImemData = mem[addr], mem[0..3] = R-type, mem[4] = HALT_WORD
//     -> Valid first high 2 cycles after Start; InstrPC 0,1,2,3,4.
//     -> Done=1 the cycle after HALT is valid; Valid=0 thereafter.
//  2 Jump=1 with Target=8'h20 at InstrPC=3
//     -> next Valid Instr has InstrPC=0x20; exactly one Valid=0 cycle between.
//  3 Branch=1, Zero=1, Offset=-2 at InstrPC=10 -> next valid InstrPC=8.
//     Same with Zero=0 -> InstrPC=11; no bubble.
//  4 Branch=1, Zero=1 and Jump=1 together, Target=5, Offset=+3 at InstrPC=1
//     -> next valid InstrPC=5 (Jump wins).
//  5 PC=8'hFF, no redirect -> next InstrPC=0.
//     Branch at InstrPC=8'hFE with Offset=+4 -> InstrPC=2.
//  6 Reset asserted mid-run, coincident with a taken Jump -> next edge IDLE, PC=0, Valid=0, Done=0.
//     Start held high through the run -> no restart until Start falls and rises again.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, captures each fetched word with a Valid
// qualifier and applies jump/branch redirects coming back from the decoder.
module instr_fetch_seq #(
  parameter int             PCW       = 8,
  parameter int             IW        = 9,
  parameter int             OFFW      = 5,
  parameter logic [IW-1:0]  HALT_WORD = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  output logic [PCW-1:0]  ImemAddr,
  input  logic [IW-1:0]   ImemData,
  input  logic            Branch,
  input  logic            Zero,
  input  logic            Jump,
  input  logic [PCW-1:0]  Target,
  input  logic [OFFW-1:0] Offset,
  output logic [IW-1:0]   Instr,
  output logic [2:0]      Opcode,
  output logic [1:0]      Func,
  output logic [PCW-1:0]  InstrPC,
  output logic            Valid,
  output logic            Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            start_q;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [PCW-1:0]  instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;

  logic            start_rise;
  logic            halt_hit;
  logic            take_jump;
  logic            take_branch;
  logic [PCW-1:0]  branch_target;

  // Redirects are only honoured while the current word is live.
  assign start_rise    = Start & ~start_q;
  assign halt_hit      = valid_q && (instr_q == HALT_WORD);
  assign take_jump     = valid_q & Jump;
  assign take_branch   = valid_q & Branch & Zero;
  assign branch_target = instr_pc_q + {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_rise) state_d = ST_RUN;
      ST_RUN:  if (halt_hit)   state_d = ST_HALT;
      ST_HALT: if (start_rise) state_d = ST_RUN;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Done = (state_q == ST_HALT);
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_hit) begin
          pc_d = pc_q;
        end else if (take_jump) begin
          pc_d = Target;
        end else if (take_branch) begin
          pc_d = branch_target;
        end else begin
          // Normal fetch; the word at the old PC is dropped on a redirect (one bubble).
          pc_d       = pc_q + PC_ONE;
          instr_d    = ImemData;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
        end
      end
      default: pc_d = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      start_q    <= Start;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign ImemAddr = pc_q;
  assign Instr    = instr_q;
  assign Opcode   = instr_q[IW-1:IW-3];
  assign Func     = instr_q[1:0];
  assign InstrPC  = instr_pc_q;
  assign Valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios plus randomized control inputs, checked
// against an expected-stream model (queue of upcoming InstrPCs, -1 marks a bubble).
module tb_instr_fetch_seq;

  localparam logic [8:0] HALT = 9'h1FF;

  logic       Clk = 1'b0;
  logic       Reset, Start, Branch, Zero, Jump;
  logic [7:0] ImemAddr, Target, InstrPC;
  logic [8:0] ImemData, Instr;
  logic [4:0] Offset;
  logic [2:0] Opcode;
  logic [1:0] Func;
  logic       Valid, Done;

  logic [8:0] mem [256];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: mode 0 idle, 1 run, 2 halt.
  int         m_mode;
  int         exp_q[$];
  bit         cur_valid;
  logic [7:0] cur_pc;
  bit         cur_done;
  bit         prev_start;

  instr_fetch_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ImemAddr (ImemAddr),
    .ImemData (ImemData),
    .Branch   (Branch),
    .Zero     (Zero),
    .Jump     (Jump),
    .Target   (Target),
    .Offset   (Offset),
    .Instr    (Instr),
    .Opcode   (Opcode),
    .Func     (Func),
    .InstrPC  (InstrPC),
    .Valid    (Valid),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  assign ImemData = mem[ImemAddr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    check("valid", {31'd0, Valid}, {31'd0, cur_valid});
    check("done", {31'd0, Done}, {31'd0, cur_done});
    if (cur_valid) begin
      check("instr_pc", {24'd0, InstrPC}, {24'd0, cur_pc});
      check("instr", {23'd0, Instr}, {23'd0, mem[cur_pc]});
      check("opcode", {29'd0, Opcode}, {29'd0, mem[cur_pc][8:6]});
      check("func", {30'd0, Func}, {30'd0, mem[cur_pc][1:0]});
    end
    if (m_mode == 0) check("idle_addr", {24'd0, ImemAddr}, 32'd0);
    $display("t=%0t valid=%0b ipc=%02h instr=%03h done=%0b", $time, Valid, InstrPC, Instr, Done);
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    int  nxt;
    int  so;
    bit  rise;
    if (Reset) begin
      m_mode = 0; exp_q.delete(); cur_valid = 0; cur_pc = 8'd0; cur_done = 0; prev_start = 0;
      return;
    end
    rise       = Start && !prev_start;
    prev_start = Start;
    if (m_mode != 1) begin
      cur_valid = 0;
      if (rise) begin
        m_mode = 1; cur_done = 0; exp_q.delete(); exp_q.push_back(0);
      end
    end else if (cur_valid && mem[cur_pc] == HALT) begin
      m_mode = 2; cur_done = 1; cur_valid = 0; exp_q.delete();
    end else begin
      if (cur_valid) begin
        if (Jump) begin
          exp_q.push_back(-1); exp_q.push_back(int'(Target));
        end else if (Branch && Zero) begin
          so = int'(Offset);
          if (so >= 16) so = so - 32;
          exp_q.push_back(-1); exp_q.push_back((int'(cur_pc) + so + 256) % 256);
        end else begin
          exp_q.push_back((int'(cur_pc) + 1) % 256);
        end
      end
      nxt = exp_q.pop_front();
      cur_valid = (nxt >= 0);
      if (nxt >= 0) cur_pc = 8'(nxt);
    end
  endtask

  task automatic step(input bit j, input bit b, input bit z, input logic [7:0] t, input logic [4:0] o);
    Jump = j; Branch = b; Zero = z; Target = t; Offset = o;
    model_edge();
    @(posedge Clk);
    #1;
    check_cycle();
  endtask

  task automatic run_until(input logic [7:0] pc);
    int n = 0;
    while (!(cur_valid && cur_pc == pc) && n < 300) begin
      step(0, 0, 0, 8'd0, 5'd0);
      n++;
    end
    if (n >= 300) begin
      mismatched++;
      $error("FAIL reach_pc: observed step budget exhausted expected pc %02h", pc);
    end
  endtask

  task automatic fill_mem(input bit rtype);
    for (int i = 0; i < 256; i++) begin
      if (rtype) mem[i] = {3'b000, 6'($urandom)};
      else       mem[i] = 9'($urandom_range(0, 510));
    end
  endtask

  initial begin
    Reset = 1; Start = 0; Jump = 0; Branch = 0; Zero = 0; Target = 0; Offset = 0;
    m_mode = 0; cur_valid = 0; cur_pc = 0; cur_done = 0; prev_start = 0;
    fill_mem(1);
    mem[4] = HALT;

    // Reset state
    step(0, 0, 0, 8'd0, 5'd0);
    step(0, 0, 0, 8'd0, 5'd0);
    check("rst_instr", {23'd0, Instr}, 32'd0);
    check("rst_instr_pc", {24'd0, InstrPC}, 32'd0);
    Reset = 0;
    step(0, 0, 0, 8'd0, 5'd0);
    step(0, 0, 0, 8'd0, 5'd0);

    // Straight-line run to HALT at address 4, Start held high throughout
    Start = 1;
    for (int k = 0; k < 20 && !cur_done; k++) step(0, 0, 0, 8'd0, 5'd0);
    repeat (3) step(0, 0, 0, 8'd0, 5'd0);
    check("halt_addr_held", {31'd0, Done}, 32'd1);

    // Restart needs a fresh Start rise
    fill_mem(0);
    Start = 0;
    step(0, 0, 0, 8'd0, 5'd0);
    Start = 1;
    step(0, 0, 0, 8'd0, 5'd0);

    run_until(8'd3);    step(1, 0, 0, 8'h20, 5'd0);
    run_until(8'h22);   step(1, 0, 0, 8'd10, 5'd0);
    run_until(8'd10);   step(0, 1, 1, 8'd0, 5'h1E);
    run_until(8'd8);
    check("branch_back_pc", {24'd0, InstrPC}, 32'd8);
    step(1, 0, 0, 8'd10, 5'd0);
    run_until(8'd10);   step(0, 1, 0, 8'd0, 5'h1E);
    check("not_taken_pc", {24'd0, InstrPC}, 32'd11);
    step(1, 0, 0, 8'd1, 5'd0);
    run_until(8'd1);    step(1, 1, 1, 8'd5, 5'd3);
    run_until(8'd5);
    check("jump_wins_pc", {24'd0, InstrPC}, 32'd5);
    step(1, 0, 0, 8'hFD, 5'd0);
    run_until(8'hFF);   step(0, 0, 0, 8'd0, 5'd0);
    check("wrap_pc", {24'd0, InstrPC}, 32'd0);
    step(1, 0, 0, 8'hFE, 5'd0);
    run_until(8'hFE);   step(0, 1, 1, 8'd0, 5'd4);
    run_until(8'd2);
    check("branch_wrap_pc", {24'd0, InstrPC}, 32'd2);

    // Randomized control inputs, including redirect requests during bubbles
    repeat (400) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           8'($urandom), 5'($urandom));
    end

    // Reset coincident with a taken jump
    for (int k = 0; k < 5 && !cur_valid; k++) step(0, 0, 0, 8'd0, 5'd0);
    Reset = 1; Start = 0;
    step(1, 0, 0, 8'h40, 5'd0);
    check("rst_mid_addr", {24'd0, ImemAddr}, 32'd0);
    Reset = 0;
    repeat (3) step(0, 0, 0, 8'd0, 5'd0);
    Start = 1;
    step(0, 0, 0, 8'd0, 5'd0);
    run_until(8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
